// File: rtl/arp_pkg.sv
// Shared types for the ARP reply scheduler: target bundle,
// FSM state encoding and address widths.
package arp_pkg;

  localparam int ARP_TPA_W = 32;
  localparam int ARP_THA_W = 48;

  typedef struct packed {
    logic [ARP_THA_W-1:0] tha;
    logic [ARP_TPA_W-1:0] tpa;
  } arp_target_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    SEND,
    GAP
  } arp_state_e;

endpackage

// File: rtl/arp_target_fifo.sv
// Circular FIFO of pending ARP reply targets; exposes the raw
// entries and a per-entry valid vector so callers can search it.
module arp_target_fifo
  import arp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  arp_target_t             i_din,
  input  logic                    i_pop,
  output arp_target_t             o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [AW:0]             o_count,
  output logic [DEPTH-1:0]        o_valid,
  output arp_target_t [DEPTH-1:0] o_mem
);

  localparam int unsigned FULLN = DEPTH;

  arp_target_t [DEPTH-1:0] r_mem;
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [AW:0]             r_cnt;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_cnt == FULLN[AW:0]);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign o_mem   = r_mem;

  // full comes from the registered count, so a pop never frees a slot
  // for a push in the same cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    logic [AW-1:0] off;
    o_valid = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = AW'(i) - r_rd;
      o_valid[i] = ({1'b0, off} < r_cnt);
    end
  end

endmodule

// File: rtl/arp_reply_sched.sv
// Schedules queued ARP replies onto the shared MAC TX path.
// Optional ARP_DEDUP_EN drops requests whose TPA is already pending.
module arp_reply_sched
  import arp_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int IFG_CYCLES = 24,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ARP_THA_W-1:0] req_tha,
  input  logic [ARP_TPA_W-1:0] req_tpa,
  output logic                 tx_req,
  input  logic                 tx_gnt,
  output logic                 enc_en,
  output logic [ARP_THA_W-1:0] enc_tha,
  output logic [ARP_TPA_W-1:0] enc_tpa,
  input  logic                 enc_ovalid,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output logic                 timeout_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef ARP_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  arp_state_e              r_state;
  arp_state_e              w_next;
  logic [ARP_THA_W-1:0]    r_tha;
  logic [ARP_TPA_W-1:0]    r_tpa;
  logic [7:0]              r_wd;
  logic [15:0]             r_gap;
  logic [7:0]              r_drop;

  arp_target_t             w_din;
  arp_target_t             w_head;
  arp_target_t [DEPTH-1:0] w_mem;
  logic [DEPTH-1:0]        w_valid;
  logic [AW:0]             w_cnt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_latch;
  logic                    w_dup;
  logic                    w_fly;

  assign w_din     = '{tha: req_tha, tpa: req_tpa};
  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready && !w_dup;
  assign w_fly     = (r_state == START) || (r_state == SEND);

  always_comb begin
    w_dup = w_fly && (r_tpa == req_tpa);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_mem[i].tpa == req_tpa)) w_dup = 1'b1;
    end
    w_dup = w_dup && DEDUP;
  end

  arp_target_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt),
    .o_valid (w_valid),
    .o_mem   (w_mem)
  );

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_latch     = 1'b0;
    tx_req      = 1'b0;
    enc_en      = 1'b0;
    timeout_err = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty) w_next = REQ;
      REQ: begin
        tx_req = 1'b1;
        if (tx_gnt) begin
          w_latch = 1'b1;
          w_next  = START;
        end
      end
      START, SEND: begin
        tx_req = 1'b1;
        enc_en = 1'b1;
        if (r_wd == 8'(TIMEOUT)) begin
          timeout_err = 1'b1;
          w_pop       = 1'b1;
          w_next      = GAP;
        end else if (r_state == START) begin
          if (enc_ovalid) w_next = SEND;
        end else if (!enc_ovalid) begin
          w_pop  = 1'b1;
          w_next = GAP;
        end
      end
      GAP:     if (r_gap == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tha   <= '0;
      r_tpa   <= '0;
      r_wd    <= '0;
      r_gap   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_tha <= w_head.tha;
        r_tpa <= w_head.tpa;
      end
      if (w_latch) r_wd <= '0;
      else if (w_fly) r_wd <= r_wd + 8'd1;
      if (w_next == GAP && r_state != GAP) r_gap <= 16'(IFG_CYCLES);
      else if (r_state == GAP && r_gap != '0) r_gap <= r_gap - 16'd1;
      if (req_valid && !req_ready && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign enc_tha  = r_tha;
  assign enc_tpa  = r_tpa;
  assign drop_cnt = r_drop;
  assign busy     = (r_state != IDLE) || (w_cnt != '0);

endmodule

// File: doc/arp_reply_sched.md
Name: arp_reply_sched

Overview:
- Sequences ARP replies from the ARP decoder onto the shared MAC TX path.
- Queues pending reply targets (THA/TPA) in a small circular FIFO.
- Requests the TX path from the upstream MAC TX arbiter, then drives the ARP encoder's en/tha/tpa for one full frame, followed by an inter-frame gap.
- Sits between arp_decode and the arp_encode instance, beside the MAC TX arbiter.

Parameters:
- DEPTH, 4, number of pending reply entries; power of two, ≥2.
- IFG_CYCLES, 24, idle clk cycles after each frame before the next tx_req.
- TIMEOUT, 255, max clk cycles in START+SEND before abort; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  decoder has a reply target
- req_ready  out  1  queue not full
- req_tha  in  48  requester hardware addr
- req_tpa  in  32  requester protocol addr
- tx_req  out  1  request MAC TX path
- tx_gnt  in  1  MAC TX path granted
- enc_en  out  1  encoder enable
- enc_tha  out  48  THA to encoder
- enc_tpa  out  32  TPA to encoder
- enc_ovalid  in  1  encoder output valid
- busy  out  1  FSM not IDLE or queue non-empty
- drop_cnt  out  8  saturating count of rejected requests
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All logic on posedge clk.
- Reset values: FIFO empty; FSM=IDLE; req_ready=1; tx_req=0; enc_en=0; enc_tha=0; enc_tpa=0; busy=0; drop_cnt=0; timeout_err=0.
- Reset mid-frame drops the frame and clears the queue.
- Push: req_valid && req_ready writes {tha,tpa} at wr_ptr.
- req_ready = !full, derived from the registered count.
  - A push arriving while full is rejected even if a pop occurs in the same cycle.
  - Each rejected request (req_valid && !req_ready) increments drop_cnt, saturating at 255.
- Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- FSM:
  - IDLE: if count≠0 → REQ.
  - REQ: tx_req=1. When tx_gnt=1, latch the FIFO head into enc_tha/enc_tpa and go → START.
  - START: enc_en=1, tx_req=1. When enc_ovalid=1 → SEND.
  - SEND: enc_en=1, tx_req=1. When enc_ovalid=0 → pop the head, go → GAP.
  - GAP: tx_req=0, enc_en=0. Load IFG_CYCLES into the gap counter; when it reaches 0 → IDLE.
- Watchdog: an 8-bit counter clears on entry to START and increments each cycle in START/SEND.
  - When it equals TIMEOUT: pop the head, pulse timeout_err, go → GAP.
- enc_tha/enc_tpa stay stable from the START entry until the next grant.
- tx_gnt dropping during START/SEND is ignored; the frame completes.
- Latency: push accepted on cycle N into an empty queue with FSM idle:
  - tx_req=1 at N+2.
  - If tx_gnt=1 at N+2, enc_en=1 at N+3.
- Back-to-back replies are separated by at least IFG_CYCLES+2 cycles with tx_req=0.
- busy = (state≠IDLE) || (count≠0).

Optional Feature:
- Macro: ARP_DEDUP_EN.
- Defined:
  - A pushed request whose tpa equals the tpa of any valid queued entry, or of the in-flight enc_tpa while in START/SEND, is accepted but not written.
  - req_ready still reflects !full, and drop_cnt is not incremented.
  - Comparison is combinational over all DEPTH entries plus the in-flight entry.
- Undefined: every accepted request is queued.

Decomposition:
- Shared package arp_pkg:
  - typedef arp_target_t = struct {tha[47:0], tpa[31:0]}.
  - Typedef for the FSM state enum: IDLE, REQ, START, SEND, GAP.
  - Constants ARP_TPA_W=32, ARP_THA_W=48.
- Sub-module arp_target_fifo: parameterized circular FIFO of arp_target_t with push/pop, full/empty, count, and a per-entry valid vector for dedup.
- The FSM, watchdog, IFG counter and drop counter live in arp_reply_sched.

Test Plan:
1. Single push, tha=48'h0011_2233_4455, tpa=32'hC0A8_0102, tx_gnt tied 1 → tx_req at N+2, enc_en at N+3 with enc_tha/enc_tpa equal to the pushed values; after enc_ovalid falls, tx_req=0 for 24 cycles; busy returns to 0.
2. Push 5 distinct targets back-to-back with tx_gnt=0 → first 4 accepted, 5th sees req_ready=0, drop_cnt=1. Release tx_gnt → 4 frames in FIFO order.
3. Hold enc_ovalid=0 after grant → timeout_err pulses exactly 255 cycles after START entry, head popped, next entry served after the gap.
4. Assert rst during SEND with 3 entries queued → next cycle all outputs at reset values, count=0, no further tx_req.
5. With ARP_DEDUP_EN: push tpa=32'h0A00_0001 twice, plus once more while it is in flight → exactly one frame; drop_cnt=0. Without the macro → three frames.
6. Push when full in the same cycle SEND pops → push rejected, drop_cnt increments, count goes 4→3.
